// File: rtl/bitbrick_seq_mac_if.sv
// Operand/result handshake bundle for bitbrick_seq_mac.
// master drives operands and out_ready; slave is the MAC itself.
interface bitbrick_seq_mac_if #(
    parameter int DW = 8,
    parameter int PW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] w;
    logic [1:0]    a_prec;
    logic [1:0]    w_prec;
    logic          a_signed;
    logic          w_signed;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;

    modport master (
        output in_valid, a, w, a_prec, w_prec, a_signed, w_signed, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, w, a_prec, w_prec, a_signed, w_signed, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/bitbrick_seq_mac.sv
// Sequential variable-precision multiplier: one 2b x 2b bitbrick is reused
// over all slice pairs, accumulating shifted partial products.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one (i, j) slice pair accumulated per cycle, j innermost
// DONE  | product valid, held until out_ready

module bitbrick (
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic       sx,
    input  logic       sy,
    output logic [3:0] p
);
    logic signed [2:0] xe;
    logic signed [2:0] ye;
    logic signed [3:0] pf;

    // Every 2b x 2b product (-6..9) fits in 4 bits; the caller decides
    // whether to read it back as signed or unsigned.
    assign xe = {sx & x[1], x};
    assign ye = {sy & y[1], y};
    assign pf = xe * ye;
    assign p  = pf;
endmodule

module bitbrick_seq_mac #(
    parameter int DW = 8,
    parameter int PW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    bitbrick_seq_mac_if.slave   bus,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] w_q, w_d;
    logic [1:0]    a_last_q, a_last_d;
    logic [1:0]    w_last_q, w_last_d;
    logic          a_sgn_q, a_sgn_d;
    logic          w_sgn_q, w_sgn_d;
    logic [1:0]    i_q, i_d;
    logic [1:0]    j_q, j_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] product_q, product_d;

    logic [1:0]    a_sl, w_sl;
    logic          a_sl_sgn, w_sl_sgn;
    logic [3:0]    bb_p;
    logic [3:0]    shamt;
    logic [PW-1:0] term_ext;
    logic [PW-1:0] term;
    logic [PW-1:0] acc_sum;

    // Precision code to index of the last 2-bit slice.
    function automatic logic [1:0] last_idx(input logic [1:0] prec);
        case (prec)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

    assign a_sl     = a_q[{i_q, 1'b0} +: 2];
    assign w_sl     = w_q[{j_q, 1'b0} +: 2];
    assign a_sl_sgn = a_sgn_q && (i_q == a_last_q);
    assign w_sl_sgn = w_sgn_q && (j_q == w_last_q);

    bitbrick u_bitbrick (
        .x  (a_sl),
        .y  (w_sl),
        .sx (a_sl_sgn),
        .sy (w_sl_sgn),
        .p  (bb_p)
    );

    assign term_ext = (a_sl_sgn || w_sl_sgn) ? {{(PW-4){bb_p[3]}}, bb_p}
                                             : {{(PW-4){1'b0}}, bb_p};
    assign shamt    = {1'b0, i_q, 1'b0} + {1'b0, j_q, 1'b0};
    assign term     = term_ext << shamt;
    assign acc_sum  = acc_q + term;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        w_d       = w_q;
        a_last_d  = a_last_q;
        w_last_d  = w_last_q;
        a_sgn_d   = a_sgn_q;
        w_sgn_d   = w_sgn_q;
        i_d       = i_q;
        j_d       = j_q;
        acc_d     = acc_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d  = RUN;
                    a_d      = bus.a;
                    w_d      = bus.w;
                    a_last_d = last_idx(bus.a_prec);
                    w_last_d = last_idx(bus.w_prec);
                    a_sgn_d  = bus.a_signed;
                    w_sgn_d  = bus.w_signed;
                    i_d      = '0;
                    j_d      = '0;
                    acc_d    = '0;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                if (j_q == w_last_q) begin
                    j_d = '0;
                    if (i_q == a_last_q) begin
                        state_d   = DONE;
                        product_d = acc_sum;
                    end else begin
                        i_d = i_q + 2'd1;
                    end
                end else begin
                    j_d = j_q + 2'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything, including a completing last pair.
        if (clear) begin
            state_d   = IDLE;
            acc_d     = '0;
            i_d       = '0;
            j_d       = '0;
            product_d = product_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            w_q       <= '0;
            a_last_q  <= '0;
            w_last_q  <= '0;
            a_sgn_q   <= 1'b0;
            w_sgn_q   <= 1'b0;
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            w_q       <= w_d;
            a_last_q  <= a_last_d;
            w_last_q  <= w_last_d;
            a_sgn_q   <= a_sgn_d;
            w_sgn_q   <= w_sgn_d;
            i_q       <= i_d;
            j_q       <= j_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.product   = product_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_bitbrick_seq_mac.sv
// Bench for bitbrick_seq_mac: directed corner cases plus random operations
// checked against an integer-arithmetic product model.
module tb_bitbrick_seq_mac;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic busy;
    int   total = 0;
    int   bad = 0;

    bitbrick_seq_mac_if #(.DW(8), .PW(16)) bus ();

    bitbrick_seq_mac #(.DW(8), .PW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int prec_bits(input logic [1:0] p);
        return (p == 2'b00) ? 2 : (p == 2'b01) ? 4 : 8;
    endfunction

    // Significant bits interpreted under their signedness, multiplied as integers.
    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] w,
                                             input logic [1:0] ap, input logic [1:0] wp,
                                             input logic as_, input logic ws);
        int ba, bw, va, vw, p;
        ba = prec_bits(ap);
        bw = prec_bits(wp);
        va = int'(a) & ((1 << ba) - 1);
        vw = int'(w) & ((1 << bw) - 1);
        if (as_ && ((va >> (ba - 1)) & 1) == 1) va = va - (1 << ba);
        if (ws && ((vw >> (bw - 1)) & 1) == 1) vw = vw - (1 << bw);
        p = va * vw;
        return p[15:0];
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] w,
                          input logic [1:0] ap, input logic [1:0] wp,
                          input logic as_, input logic ws,
                          input int stall, input string tag);
        int c;
        int exp_lat;
        logic [15:0] exp;
        logic ok;
        exp     = ref_prod(a, w, ap, wp, as_, ws);
        exp_lat = (prec_bits(ap) / 2) * (prec_bits(wp) / 2) + 1;
        bus.a = a; bus.w = w; bus.a_prec = ap; bus.w_prec = wp;
        bus.a_signed = as_; bus.w_signed = ws;
        bus.in_valid = 1'b1;
        bus.out_ready = (stall == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        c = 1;
        while (!bus.out_valid && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        chk({tag, "_lat"}, c, exp_lat);
        chk({tag, "_prod"}, {16'h0, bus.product}, {16'h0, exp});
        if (stall > 0) begin
            ok = 1'b1;
            for (int k = 0; k < stall; k++) begin
                bus.in_valid = 1'b1;
                bus.a = 8'($urandom);
                bus.w = 8'($urandom);
                @(posedge clk); #1;
                if (!bus.out_valid || bus.in_ready || bus.product !== exp) ok = 1'b0;
            end
            chk({tag, "_hold"}, {31'h0, ok}, 32'h1);
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, "_ovdrop"}, {31'h0, bus.out_valid}, 32'h0);
        chk({tag, "_rdy"}, {31'h0, bus.in_ready}, 32'h1);
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.w = '0; bus.a_prec = '0; bus.w_prec = '0;
        bus.a_signed = 1'b0; bus.w_signed = 1'b0;
        #1;
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_product", {16'h0, bus.product}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'h03, 8'h02, 2'b00, 2'b00, 1'b1, 1'b0, 0, "d2x2");
        chk("d2x2_val", {16'h0, bus.product}, 32'hFFFE);
        run_op(8'h80, 8'h80, 2'b10, 2'b10, 1'b1, 1'b1, 0, "d8x8s");
        chk("d8x8s_val", {16'h0, bus.product}, 32'h4000);
        run_op(8'hFF, 8'hF8, 2'b10, 2'b01, 1'b0, 1'b1, 0, "d8x4");
        chk("d8x4_val", {16'h0, bus.product}, 32'hF808);
        run_op(8'h7F, 8'h02, 2'b11, 2'b11, 1'b0, 1'b0, 0, "dp11");
        chk("dp11_val", {16'h0, bus.product}, 32'h00FE);

        // Result stalled five cycles while new operands are offered.
        run_op(8'hA5, 8'h3C, 2'b10, 2'b10, 1'b1, 1'b0, 5, "stall");
        run_op(8'h06, 8'h09, 2'b01, 2'b01, 1'b1, 1'b1, 0, "after_stall");

        // Clear during RUN cycle 3 of an 8x8 operation.
        bus.a = 8'h5A; bus.w = 8'hC3; bus.a_prec = 2'b10; bus.w_prec = 2'b10;
        bus.a_signed = 1'b1; bus.w_signed = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_busy", {31'h0, busy}, 32'h0);
        chk("clr_in_ready", {31'h0, bus.in_ready}, 32'h1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) n++;
        end
        chk("clr_no_ov", n, 0);
        run_op(8'h0B, 8'h0D, 2'b01, 2'b10, 1'b0, 1'b1, 0, "after_clr");

        // Asynchronous reset mid-RUN.
        bus.a = 8'h77; bus.w = 8'h99; bus.a_prec = 2'b10; bus.w_prec = 2'b10;
        bus.a_signed = 1'b0; bus.w_signed = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_ov", {31'h0, bus.out_valid}, 32'h0);
        chk("arst_rdy", {31'h0, bus.in_ready}, 32'h1);
        chk("arst_prod", {16'h0, bus.product}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < 60; r++) begin
            run_op(8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
                   1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
